// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a 4-phase req/ack clock-domain crossing.
// Optional CDC_TX_TIMEOUT_EN adds a per-state timeout that aborts the handshake and sets a sticky err.
module cdc_handshake_tx #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             req_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic [WIDTH-1:0] data_n;
  logic ack_s, req_n, done_n, to;
  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("cdc_handshake_tx: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end
  assign ack_s     = sync[SYNC_STAGES-1];
  assign ready_out = state == IDLE && !rst;
  assign busy      = state != IDLE;
`ifdef CDC_TX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
`endif
  always_comb begin
    state_n = state;
    req_n   = req_out;
    data_n  = data_out;
    done_n  = 1'b0;
    to      = 1'b0;
    case (state)
      IDLE:   if (valid_in) begin data_n = data_in; state_n = SETUP; end
      // a stale ack from the previous transfer must clear before req may rise
      SETUP:  if (!ack_s) begin req_n = 1'b1; state_n = REQ_HI; end
      REQ_HI: if (ack_s) begin req_n = 1'b0; state_n = REQ_LO; end
      REQ_LO: if (!ack_s) begin done_n = 1'b1; state_n = IDLE; end
    endcase
`ifdef CDC_TX_TIMEOUT_EN
    if (busy && state_n == state && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      req_n   = 1'b0;
      to      = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sync     <= '0;
      req_out  <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      sync     <= {sync[SYNC_STAGES-2:0], ack_in};
      req_out  <= req_n;
      data_out <= data_n;
      done     <= done_n;
    end
  end
`ifdef CDC_TX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= (busy && state_n == state) ? cnt + 1'b1 : '0;
      err <= err | to;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: randomized bench for cdc_handshake_tx with a behavioural responder,
// a cycle model of the handshake rules and a scoreboard of words seen by the remote side.
module tb_cdc_handshake_tx;
  localparam int W = 8;
  localparam int S = 3;
  localparam int T = 16;
  logic clk = 1'b0, rst = 1'b1, valid_in = 1'b0, ack_in = 1'b0;
  logic [W-1:0] data_in = '0, data_out;
  logic ready_out, req_out, busy, done, err;
  int checks = 0, failures = 0;
  int phase = 0, t_state = 0, since = 0, dly = 0, mode = 0;
  logic m_req = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_data = '0;
  logic lag[$];
  logic [W-1:0] exp_q[$];
  bit wait_fall = 0, wait_ready = 0, acked = 0;

  always #5 clk = ~clk;

  cdc_handshake_tx #(.WIDTH(W), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .data_out(data_out), .req_out(req_out), .ack_in(ack_in), .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ack as seen by the source lags the wire by S edges; phases 0..3 = idle, setup, req high, req low
  task automatic model_edge();
    int nxt;
    logic a;
    if (rst) begin
      phase = 0; t_state = 0;
      m_req = 1'b0; m_data = '0; m_done = 1'b0; m_err = 1'b0;
      lag = {};
      repeat (S) lag.push_back(1'b0);
      exp_q = {};
      return;
    end
    a = lag.pop_front();
    lag.push_back(ack_in);
    m_done = 1'b0;
    nxt = phase;
    if (phase == 0 && valid_in) begin m_data = data_in; exp_q.push_back(data_in); nxt = 1; end
    else if (phase == 1 && !a) begin m_req = 1'b1; nxt = 2; end
    else if (phase == 2 && a) begin m_req = 1'b0; nxt = 3; end
    else if (phase == 3 && !a) begin m_done = 1'b1; nxt = 0; end
`ifdef CDC_TX_TIMEOUT_EN
    t_state = (nxt == phase && phase != 0) ? t_state + 1 : 0;
    if (t_state == T) begin nxt = 0; m_req = 1'b0; m_err = 1'b1; t_state = 0; exp_q = {}; end
`endif
    phase = nxt;
  endtask

  // remote responder: mode 0 = 4-phase with random delay, 1 = ack stuck high, 2 = ack stuck low
  task automatic respond();
    logic nack;
    nack = ack_in;
    if (rst) nack = 1'b0;
    else if (mode == 1) nack = 1'b1;
    else if (mode == 2) nack = 1'b0;
    else if (req_out && !ack_in) begin
      if (dly > 0) dly--;
      else begin
        nack = 1'b1; acked = 1; wait_fall = 1;
        check("cap_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("capture", data_out, exp_q.pop_front());
      end
    end else if (!req_out && ack_in) begin
      if (dly > 0) dly--;
      else begin nack = 1'b0; wait_ready = acked; acked = 0; end
    end
    if (nack !== ack_in) begin since = 0; dly = $urandom_range(0, 4); end
    if (rst) begin wait_fall = 0; wait_ready = 0; acked = 0; end
    ack_in = nack;
  endtask

  task automatic observe();
    check("req", req_out, m_req);
    check("data", data_out, m_data);
    check("busy", busy, phase != 0);
    check("ready", ready_out, phase == 0 && !rst);
    check("done", done, m_done);
    check("err", err, m_err);
    if (wait_fall && !req_out) begin check("req_fall_lat", since, S + 1); wait_fall = 0; end
    if (wait_ready && ready_out) begin check("ready_lat", since, S + 1); wait_ready = 0; end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
    rst = r; valid_in = v; data_in = d;
    respond();
    @(posedge clk);
    since++;
    model_edge();
    @(negedge clk);
    observe();
  endtask

  initial begin
    int nd, k;
    logic acc;
    logic [W-1:0] w;
    repeat (3) cycle(1'b1, 1'b0, '0);
    check("rst_ready", ready_out, 1'b0);
    // single word 0xA5
    dly = 3;
    cycle(1'b0, 1'b1, 8'hA5);
    check("t1_data", data_out, 8'hA5);
    cycle(1'b0, 1'b0, '0);
    check("t1_req", req_out, 1'b1);
    nd = 0;
    for (int i = 0; i < 40; i++) begin cycle(1'b0, 1'b0, W'($urandom)); nd += int'(done); end
    check("t1_dones", nd, 1);
    check("t1_ready", ready_out, 1'b1);
    // back-to-back words 1,2,3 with valid held
    k = 0; nd = 0;
    for (int i = 0; i < 200 && k < 3; i++) begin
      acc = ready_out;
      cycle(1'b0, 1'b1, W'(k + 1));
      nd += int'(done);
      if (acc) k++;
    end
    for (int i = 0; i < 30; i++) begin cycle(1'b0, 1'b0, '0); nd += int'(done); end
    check("t2_words", k, 3);
    check("t2_dones", nd, 3);
    check("t2_drained", exp_q.size(), 0);
    // stale ack held high at accept
    mode = 1;
    repeat (6) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, '0);
      check("t3_req_low", req_out, 1'b0);
      check("t3_data", data_out, 8'h5A);
    end
    mode = 0; dly = 0; nd = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b0, '0);
      check("t3_data_hold", data_out, 8'h5A);
      nd += int'(done);
    end
    check("t3_dones", nd, 1);
    // reset while request is high
    cycle(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < 20 && phase != 2; i++) cycle(1'b0, 1'b0, '0);
    check("t4_in_req_hi", req_out, 1'b1);
    cycle(1'b1, 1'b0, '0);
    check("t4_req", req_out, 1'b0);
    check("t4_data", data_out, 8'h00);
    check("t4_busy", busy, 1'b0);
    cycle(1'b0, 1'b0, '0);
    check("t4_ready", ready_out, 1'b1);
    // input churn during a handshake
    w = W'($urandom);
    cycle(1'b0, 1'b1, w);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, !ready_out, W'($urandom));
      check("t6_data_hold", data_out, w);
    end
    // random traffic with occasional resets
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), W'($urandom));
`ifdef CDC_TX_TIMEOUT_EN
    cycle(1'b1, 1'b0, '0);
    mode = 2;
    cycle(1'b0, 1'b1, 8'h77);
    cycle(1'b0, 1'b0, '0);
    check("to_req_up", req_out, 1'b1);
    k = 0;
    while (req_out && k < 40) begin cycle(1'b0, 1'b0, '0); k++; end
    check("to_lat", k, T);
    check("to_err", err, 1'b1);
    check("to_ready", ready_out, 1'b1);
    mode = 0;
    cycle(1'b0, 1'b1, 8'h11);
    repeat (30) cycle(1'b0, 1'b0, '0);
    check("to_err_sticky", err, 1'b1);
`endif
    repeat (30) cycle(1'b0, 1'b0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
